// File: rtl/hysteresis_counter_table.sv
// -----------------------------------------------------------------------------
// hysteresis_counter_table
//
// Table of DEPTH saturating counters (0..RANGE-1) with a hysteresis jump across
// the mid-point: moving up out of HALF_LOW lands on HALF_HIGH+COERCIVITY, and
// moving down out of HALF_HIGH lands on HALF_LOW-COERCIVITY. That makes the
// taken/not-taken decision (count >= RANGE/2) resist flipping back on a single
// contrary event.
//
// A flush pulse starts a sweep that rewrites one entry per cycle, from index 0
// up to DEPTH-1, to RESET_VALUE. While the sweep runs, busy is high and reads,
// updates and further flush pulses are dropped.
//
// Optional feature (macro HYSTERESIS_COUNTER_TABLE_BYPASS_EN):
//   defined   -> a read and an update to the same index in the same cycle
//                returns the post-update value.
//   undefined -> the same collision returns the pre-update value.
//   In both builds the update itself is applied.
//
// Ports
//   clock              in   single clock, rising edge
//   resetn             in   asynchronous active-low reset
//   read_enable        in   read request (accepted when busy is low)
//   read_index         in   entry to read
//   read_count         out  registered entry value, 1-cycle read latency
//   read_decision      out  read_count >= RANGE/2 (combinational)
//   update_enable      in   update request (accepted when busy is low)
//   update_index       in   entry to update
//   increment          in   count up
//   decrement          in   count down
//   flush              in   start a reinitialisation sweep
//   busy               out  sweep in progress
//   debug_flush_state  out  flush FSM state (0 = IDLE, 1 = FLUSH)
//
// Handshake: there is no back-pressure. A request is taken on the rising edge
// where its enable is high and busy is low; otherwise it is silently dropped.
// -----------------------------------------------------------------------------
module hysteresis_counter_table #(
    parameter int DEPTH       = 16,
    parameter int RANGE       = 4,
    parameter int RESET_VALUE = 0,
    parameter int COERCIVITY  = 1,
    parameter int WIDTH       = $clog2(RANGE),
    parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   read_enable,
    input  logic [INDEX_WIDTH-1:0] read_index,
    output logic [WIDTH-1:0]       read_count,
    output logic                   read_decision,
    input  logic                   update_enable,
    input  logic [INDEX_WIDTH-1:0] update_index,
    input  logic                   increment,
    input  logic                   decrement,
    input  logic                   flush,
    output logic                   busy,
    output logic                   debug_flush_state
);

    localparam logic [WIDTH-1:0]       RESET_V     = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0]       MAX_V       = WIDTH'(RANGE - 1);
    localparam logic [WIDTH-1:0]       HALF_LOW_V  = WIDTH'(RANGE / 2 - 1);
    localparam logic [WIDTH-1:0]       HALF_HIGH_V = WIDTH'(RANGE / 2);
    localparam logic [WIDTH-1:0]       JUMP_UP_V   = WIDTH'(RANGE / 2 + COERCIVITY);
    localparam logic [WIDTH-1:0]       JUMP_DN_V   = WIDTH'(RANGE / 2 - 1 - COERCIVITY);
    localparam logic [WIDTH-1:0]       ONE_V       = WIDTH'(1);
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX    = INDEX_WIDTH'(DEPTH - 1);
    // One extra bit so indexes past a non-power-of-2 DEPTH can be detected.
    localparam logic [INDEX_WIDTH:0]   DEPTH_EXT   = (INDEX_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] sweep_idx_q, sweep_idx_d;
    logic [WIDTH-1:0]       entry_q [DEPTH];
    logic [WIDTH-1:0]       entry_d [DEPTH];
    logic [WIDTH-1:0]       read_count_q, read_count_d;

    logic                   busy_w;
    logic                   upd_in_range;
    logic                   rd_in_range;
    logic                   upd_accept;
    logic                   rd_accept;
    logic [WIDTH-1:0]       upd_cur;
    logic [WIDTH-1:0]       upd_next;
    logic [WIDTH-1:0]       rd_cur;

    // Saturating step with the hysteresis jump across the mid-point.
    // Both or neither direction leaves the value unchanged.
    function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cur,
                                                    input logic             inc,
                                                    input logic             dec);
        logic [WIDTH-1:0] nxt;
        nxt = cur;
        if (inc && !dec) begin
            if (cur == MAX_V)           nxt = cur;
            else if (cur == HALF_LOW_V) nxt = JUMP_UP_V;
            else                        nxt = cur + ONE_V;
        end else if (dec && !inc) begin
            if (cur == '0)               nxt = cur;
            else if (cur == HALF_HIGH_V) nxt = JUMP_DN_V;
            else                         nxt = cur - ONE_V;
        end
        return nxt;
    endfunction

    assign busy_w            = (state_q == S_FLUSH);
    assign busy              = busy_w;
    assign debug_flush_state = logic'(state_q);

    assign upd_in_range = ({1'b0, update_index} < DEPTH_EXT);
    assign rd_in_range  = ({1'b0, read_index} < DEPTH_EXT);

    assign upd_accept = update_enable && !busy_w && upd_in_range;
    assign rd_accept  = read_enable && !busy_w;

    assign upd_cur  = upd_in_range ? entry_q[update_index] : RESET_V;
    assign upd_next = next_count(upd_cur, increment, decrement);
    // Out-of-range reads see the reset value rather than a missing entry.
    assign rd_cur   = rd_in_range ? entry_q[read_index] : RESET_V;

    // ------------------------------------------------------------------
    // Flush FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d     = S_FLUSH;
                    sweep_idx_d = '0;
                end
            end
            S_FLUSH: begin
                // Flush pulses are ignored here; the sweep always completes.
                if (sweep_idx_q == LAST_IDX) begin
                    state_d     = S_IDLE;
                    sweep_idx_d = '0;
                end else begin
                    sweep_idx_d = sweep_idx_q + INDEX_WIDTH'(1);
                end
            end
            default: begin
                state_d     = S_IDLE;
                sweep_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage. An update accepted in the same IDLE cycle as a flush
    // pulse lands first; the sweep overwrites it later.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (upd_accept) begin
            entry_d[update_index] = upd_next;
        end
        if (busy_w) begin
            entry_d[sweep_idx_q] = RESET_V;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= RESET_V;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port: registered, holds when no read is accepted.
    // ------------------------------------------------------------------
    always_comb begin
        read_count_d = read_count_q;
        if (rd_accept) begin
            read_count_d = rd_cur;
`ifdef HYSTERESIS_COUNTER_TABLE_BYPASS_EN
            // Forward the value being written this cycle to a colliding read.
            if (upd_accept && (update_index == read_index)) begin
                read_count_d = upd_next;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            read_count_q <= RESET_V;
        end else begin
            read_count_q <= read_count_d;
        end
    end

    assign read_count    = read_count_q;
    assign read_decision = (read_count_q >= HALF_HIGH_V);

endmodule

// File: tb/tb_hysteresis_counter_table.sv
module tb_hysteresis_counter_table;

  localparam int DEPTH       = 16;
  localparam int RANGE       = 8;
  localparam int RESET_VALUE = 0;
  localparam int COERCIVITY  = 2;
  localparam int WIDTH       = 3;
  localparam int IW          = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic          read_enable = 1'b0;
  logic [IW-1:0] read_index = '0;
  logic [WIDTH-1:0] read_count;
  logic          read_decision;
  logic          update_enable = 1'b0;
  logic [IW-1:0] update_index = '0;
  logic          increment = 1'b0;
  logic          decrement = 1'b0;
  logic          flush = 1'b0;
  logic          busy;
  logic          debug_flush_state;

  hysteresis_counter_table #(
    .DEPTH(DEPTH), .RANGE(RANGE), .RESET_VALUE(RESET_VALUE),
    .COERCIVITY(COERCIVITY), .WIDTH(WIDTH), .INDEX_WIDTH(IW)
  ) dut (
    .clock(clock), .resetn(resetn),
    .read_enable(read_enable), .read_index(read_index),
    .read_count(read_count), .read_decision(read_decision),
    .update_enable(update_enable), .update_index(update_index),
    .increment(increment), .decrement(decrement),
    .flush(flush), .busy(busy), .debug_flush_state(debug_flush_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on plain integers from the counting rules; the sweep is modelled as
  // "all entries become RESET_VALUE, busy for DEPTH cycles", which is what is
  // observable since every access during the sweep is dropped.
  int m_entry [DEPTH];
  int m_rd;
  int m_busy_left;

  function automatic int ref_next(input int v, input bit inc, input bit dec);
    int half;
    half = RANGE / 2;
    if (inc == dec) return v;
    if (inc) begin
      if (v == RANGE - 1) return v;
      if (v == half - 1)  return half + COERCIVITY;
      return v + 1;
    end
    if (v == 0)    return 0;
    if (v == half) return half - 1 - COERCIVITY;
    return v - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_entry[i] = RESET_VALUE;
    m_rd = RESET_VALUE;
    m_busy_left = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Advance model with the currently driven inputs, then clock the DUT.
  task automatic step();
    int nv;
    if (m_busy_left == 0) begin
      nv = ref_next(m_entry[int'(update_index)], increment, decrement);
      if (read_enable) begin
        m_rd = m_entry[int'(read_index)];
`ifdef HYSTERESIS_COUNTER_TABLE_BYPASS_EN
        if (update_enable && update_index == read_index) m_rd = nv;
`endif
      end
      if (update_enable) m_entry[int'(update_index)] = nv;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) m_entry[i] = RESET_VALUE;
        m_busy_left = DEPTH;
      end
    end else begin
      m_busy_left--;
    end
    tick();
  endtask

  task automatic idle_inputs();
    read_enable = 1'b0;
    update_enable = 1'b0;
    increment = 1'b0;
    decrement = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_update(input int idx, input bit inc, input bit dec);
    update_enable = 1'b1;
    update_index = IW'(idx);
    increment = inc;
    decrement = dec;
    step();
    idle_inputs();
  endtask

  task automatic do_read(input int idx);
    read_enable = 1'b1;
    read_index = IW'(idx);
    step();
    idle_inputs();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit upd_en;
    int upd_idx;
    bit inc;
    bit dec;
    int rd_idx;
    int exp_cnt;
    bit exp_dec;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input bit ue, input int ui, input bit inc, input bit dec,
                         input int ri, input int ec, input bit ed);
    vec_t v;
    v.upd_en = ue; v.upd_idx = ui; v.inc = inc; v.dec = dec;
    v.rd_idx = ri; v.exp_cnt = ec; v.exp_dec = ed;
    vq.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    int guard;
    int exp_col;

    model_reset();

    // ---- reset state ----
    tick();
    tick();
    check("reset read_count", int'(read_count), RESET_VALUE);
    check("reset read_decision", int'(read_decision), 0);
    check("reset busy", int'(busy), 0);
    check("reset fsm state", int'(debug_flush_state), 0);
    resetn = 1'b1;
    tick();

    // ---- table: entry 5 up/down walk, entry 3 inc+dec, neighbour 4 ----
    add_vec(1, 5, 1, 0, 5, 1, 0);
    add_vec(1, 5, 1, 0, 5, 2, 0);
    add_vec(1, 5, 1, 0, 5, 3, 0);
    add_vec(1, 5, 1, 0, 5, 6, 1);
    add_vec(1, 5, 1, 0, 5, 7, 1);
    add_vec(1, 5, 1, 0, 5, 7, 1);
    add_vec(1, 5, 1, 0, 5, 7, 1);
    add_vec(1, 5, 0, 1, 5, 6, 1);
    add_vec(1, 5, 0, 1, 5, 5, 1);
    add_vec(1, 5, 0, 1, 5, 4, 1);
    add_vec(1, 5, 0, 1, 5, 1, 0);
    add_vec(1, 5, 0, 1, 5, 0, 0);
    add_vec(1, 5, 0, 1, 5, 0, 0);
    add_vec(1, 3, 1, 0, 3, 1, 0);
    add_vec(1, 3, 1, 0, 3, 2, 0);
    add_vec(1, 3, 1, 1, 3, 2, 0);
    add_vec(1, 3, 0, 0, 3, 2, 0);
    add_vec(0, 0, 0, 0, 4, 0, 0);

    foreach (vq[k]) begin
      update_enable = vq[k].upd_en;
      update_index = IW'(vq[k].upd_idx);
      increment = vq[k].inc;
      decrement = vq[k].dec;
      step();
      idle_inputs();
      do_read(vq[k].rd_idx);
      check($sformatf("table[%0d] count", k), int'(read_count), vq[k].exp_cnt);
      check($sformatf("table[%0d] decision", k), int'(read_decision), int'(vq[k].exp_dec));
    end

    // ---- read/update collision on entry 9 ----
    do_update(9, 1, 0);
    do_update(9, 1, 0);
    do_update(9, 1, 0);
    do_read(9);
    check("entry9 pre-collision", int'(read_count), 3);
    update_enable = 1'b1; update_index = 4'd9; increment = 1'b1;
    read_enable = 1'b1; read_index = 4'd9;
    step();
    idle_inputs();
`ifdef HYSTERESIS_COUNTER_TABLE_BYPASS_EN
    exp_col = 6;
`else
    exp_col = 3;
`endif
    check("collision read", int'(read_count), exp_col);
    do_read(9);
    check("post-collision read", int'(read_count), 6);

    // ---- flush with a same-cycle update, accesses dropped while busy ----
    update_enable = 1'b1; update_index = 4'd2; increment = 1'b1;
    flush = 1'b1;
    step();
    idle_inputs();
    check("busy after flush", int'(busy), 1);
    check("fsm state flushing", int'(debug_flush_state), 1);
    busy_cycles = 1;
    guard = 0;
    read_enable = 1'b1; read_index = 4'd3;
    update_enable = 1'b1; update_index = 4'd15; increment = 1'b1;
    flush = 1'b1;
    while (busy && guard < 40) begin
      step();
      guard++;
      if (busy) busy_cycles++;
    end
    idle_inputs();
    check("flush busy cycles", busy_cycles, DEPTH);
    check("read_count held during busy", int'(read_count), 6);
    for (int i = 0; i < DEPTH; i++) begin
      do_read(i);
      check($sformatf("after flush entry%0d", i), int'(read_count), RESET_VALUE);
    end

    // ---- reset asserted mid-sweep ----
    do_update(12, 1, 0);
    do_update(12, 1, 0);
    do_read(12);
    check("entry12 before flush", int'(read_count), 2);
    flush = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 6; i++) step();
    check("busy at sweep cycle 7", int'(busy), 1);
    resetn = 1'b0;
    #1;
    model_reset();
    check("busy on mid-flush reset", int'(busy), 0);
    check("read_count on mid-flush reset", int'(read_count), RESET_VALUE);
    tick();
    resetn = 1'b1;
    tick();
    check("fsm idle after reset", int'(debug_flush_state), 0);
    do_read(12);
    check("entry12 after reset", int'(read_count), RESET_VALUE);
    do_read(5);
    check("entry5 after reset", int'(read_count), RESET_VALUE);

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 400; n++) begin
      read_enable = 1'($urandom_range(0, 1));
      read_index = IW'($urandom_range(0, DEPTH - 1));
      update_enable = 1'($urandom_range(0, 1));
      // Small index range raises the collision rate.
      update_index = IW'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) read_index = update_index;
      increment = 1'($urandom_range(0, 1));
      decrement = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 59) == 0);
      step();
      check("rand read_count", int'(read_count), m_rd);
      check("rand read_decision", int'(read_decision), int'(m_rd >= RANGE / 2));
      check("rand busy", int'(busy), int'(m_busy_left > 0));
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hysteresis_counter_table.md
HYSTERESIS_COUNTER_TABLE -- requirements
Module: hysteresis_counter_table

Interface
REQ-001 Parameter DEPTH, default 16: number of independent counter entries; SHALL be at least 2.
REQ-002 Parameter RANGE, default 4: states per entry (0..RANGE-1); SHALL be even and at least 4.
REQ-003 Parameter RESET_VALUE, default 0: value of every entry after reset or flush; SHALL be below RANGE.
REQ-004 Parameter COERCIVITY, default 1: hysteresis jump width; SHALL satisfy 0 <= COERCIVITY <= RANGE/2-1.
REQ-005 Parameter WIDTH, default CLOG2(RANGE): entry width.
REQ-006 Parameter INDEX_WIDTH, default CLOG2(DEPTH): index width.
REQ-007 clock  input  1  single clock; all state SHALL change on its rising edge only.
REQ-008 resetn  input  1  asynchronous, active-low reset.
REQ-009 read_enable  input  1  read request.
REQ-010 read_index  input  INDEX_WIDTH  entry to read.
REQ-011 read_count  output  WIDTH  registered entry value.
REQ-012 read_decision  output  1  high when read_count >= RANGE/2.
REQ-013 update_enable  input  1  update request.
REQ-014 update_index  input  INDEX_WIDTH  entry to update.
REQ-015 increment  input  1  count up, qualified by update_enable.
REQ-016 decrement  input  1  count down, qualified by update_enable.
REQ-017 flush  input  1  pulse: start reinitialisation of all entries.
REQ-018 busy  output  1  high while a flush sweep is in progress.

Function
REQ-019 Entry update SHALL apply only when update_enable is high and busy is low, with HALF_LOW = RANGE/2-1 and HALF_HIGH = RANGE/2.
REQ-020 Increment alone: max stays max; HALF_LOW jumps to HALF_HIGH+COERCIVITY; any other value adds 1.
REQ-021 Decrement alone: 0 stays 0; HALF_HIGH jumps to HALF_LOW-COERCIVITY; any other value subtracts 1.
REQ-022 Increment and decrement together, or neither, SHALL leave the entry unchanged.
REQ-023 Read: when read_enable is high and busy is low, read_count SHALL show entry[read_index] the cycle after the request (1-cycle latency).
REQ-024 read_count SHALL hold its value when no read is accepted.
REQ-025 read_decision SHALL be combinational from read_count.
REQ-026 The flush FSM SHALL have two states, IDLE and FLUSH.
REQ-027 IDLE to FLUSH: on flush high; busy rises the next cycle.
REQ-028 In FLUSH, one entry per cycle SHALL be written to RESET_VALUE in ascending index order, from 0 to DEPTH-1.
REQ-029 FLUSH to IDLE: after entry DEPTH-1 is written; busy is high for exactly DEPTH cycles.
REQ-030 The flush input SHALL be ignored while busy is high.
REQ-031 Reads and updates presented while busy is high SHALL be dropped; read_count holds.
REQ-032 A flush and an update in the same IDLE cycle: the update SHALL apply first, then the sweep overwrites it.
REQ-033 Indexes at or above DEPTH (non-power-of-2 DEPTH): updates SHALL be dropped; reads SHALL return RESET_VALUE.

Reset
REQ-034 While resetn is low, every entry, read_count and the FSM SHALL be forced asynchronously: entries and read_count to RESET_VALUE, FSM to IDLE, busy to 0.
REQ-035 Reset asserted mid-flush SHALL abort the sweep; after release the block is in IDLE.

Configuration
REQ-036 Macro HYSTERESIS_COUNTER_TABLE_BYPASS_EN controls read-during-update forwarding.
REQ-037 With HYSTERESIS_COUNTER_TABLE_BYPASS_EN defined, a read and an update to the same index in the same cycle SHALL return the post-update value.
REQ-038 With the macro undefined, the same collision SHALL return the pre-update value; the update still applies.

Verification (RANGE=8, COERCIVITY=2, DEPTH=16, RESET_VALUE=0)
REQ-039 Entry 5: seven increments then read -> 1,2,3,6,7,7,7; read_count=7, read_decision=1.
REQ-040 From 7 on entry 5: decrements -> 6,5,4,1,0,0; read_decision falls at 1.
REQ-041 Entry 3 at 2: increment and decrement together -> stays 2; update to index 3 does not alter index 4.
REQ-042 Entry 9 at 3: update(+1) and read of index 9 in the same cycle -> read_count=6 with the macro, 3 without; a later read returns 6 in both builds.
REQ-043 Flush pulse with entries non-zero -> busy high for 16 cycles; reads and updates during busy are dropped; afterwards all reads return 0.
REQ-044 resetn low at cycle 7 of a flush -> busy=0 immediately, all entries and read_count=0, FSM IDLE after release.
